intfdemuxn: RTL and testbench

Parametrised successor of the FPGA-integration demux. It captures LINEBIT-wide line data at DEMUX sample points, MAXTS synclk cycles apart, aligned to a slow sync strobe, and assembles them into one DATABIT word per sync frame. Over the earlier fixed block it adds:
- a runtime capture offset
- a bit-order option
- an output valid strobe
- a sync-period lock monitor with error pulse

It sits between the high-speed line interface and the per-word framer logic.

---
 rtl/intfdemuxn_pkg.sv | 26 ++
 rtl/intfsynmon.sv | 66 ++++++
 rtl/intfdemuxn.sv | 134 +++++++++++++
 tb/tb_intfdemuxn.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/intfdemuxn_pkg.sv
// Shared parameter header for the line demux/mux pair: DEMUX limits, phase
// counter width and the default intfdemuxn parameter set.
package intfdemuxn_pkg;

   localparam int DEMUX_MIN = 1;
   localparam int DEMUX_MAX = 8;
   localparam int PHBIT     = 3;

   localparam int DEF_LINEBIT  = 1;
   localparam int DEF_DEMUX    = 4;
   localparam int DEF_BITTS    = 3;
   localparam int DEF_MAXTS    = 6;
   localparam int DEF_SYNPER   = 24;
   localparam int DEF_PBIT     = 8;
   localparam int DEF_LOCKN    = 2;
   localparam int DEF_MSBFIRST = 1;
   localparam int DEF_VLDLOCK  = 0;

   typedef enum logic [1:0] {
      SYN_NONE = 2'd0,
      SYN_GOOD = 2'd1,
      SYN_BAD  = 2'd2,
      SYN_MISS = 2'd3
   } syn_evt_e;

endpackage

// File: rtl/intfsynmon.sv
// Sync period monitor: measures the spacing of detected sync edges, flags
// early or missing edges and declares lock after LOCKN good periods.
module intfsynmon
   import intfdemuxn_pkg::*;
#(
   parameter int SYNPER = DEF_SYNPER,
   parameter int PBIT   = DEF_PBIT,
   parameter int LOCKN  = DEF_LOCKN
) (
   input  logic synclk,
   input  logic rst_,
   input  logic posdet,
   output logic locked,
   output logic synerr
);

   localparam logic [PBIT-1:0] PER_LAST = PBIT'(SYNPER - 1);
   localparam logic [PBIT-1:0] PER_SAT  = PBIT'(SYNPER);
   localparam logic [2:0]      LOCK_TGT = 3'(LOCKN);

   logic [PBIT-1:0] pcnt;
   logic [2:0]      goodcnt;
   syn_evt_e        evt;

   // An edge seen with pcnt already saturated was reported as missing, so it
   // only restarts the period count.
   always_comb begin
      evt = SYN_NONE;
      if (posdet) begin
         if (pcnt == PER_LAST) begin
            evt = SYN_GOOD;
         end else if (pcnt < PER_LAST) begin
            evt = SYN_BAD;
         end
      end else if (pcnt == PER_LAST) begin
         evt = SYN_MISS;
      end
   end

   always_ff @(posedge synclk or negedge rst_) begin
      if (!rst_) begin
         pcnt    <= PER_SAT;
         goodcnt <= '0;
         synerr  <= 1'b0;
      end else begin
         if (posdet) begin
            pcnt <= '0;
         end else if (pcnt != PER_SAT) begin
            pcnt <= pcnt + 1'b1;
         end
         synerr <= (evt == SYN_BAD) || (evt == SYN_MISS);
         case (evt)
            SYN_GOOD: begin
               if (goodcnt != LOCK_TGT) begin
                  goodcnt <= goodcnt + 1'b1;
               end
            end
            SYN_BAD, SYN_MISS: goodcnt <= '0;
            default: ;
         endcase
      end
   end

   assign locked = (goodcnt == LOCK_TGT);

endmodule

// File: rtl/intfdemuxn.sv
// Line demux: captures LINEBIT samples MAXTS cycles apart after each sync
// edge (plus a runtime offset) and assembles them into one DATABIT word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no word in progress, cntph parked at DEMUX-1
// ST_DLY  | sync seen, ofscnt counting down to the capture cycle
// ST_ASM  | sample 0 taken, cntts/cntph stepping through remaining slots
module intfdemuxn
   import intfdemuxn_pkg::*;
#(
   parameter int  LINEBIT  = DEF_LINEBIT,
   parameter int  DEMUX    = DEF_DEMUX,
   parameter int  BITTS    = DEF_BITTS,
   parameter int  MAXTS    = DEF_MAXTS,
   parameter int  SYNPER   = DEF_SYNPER,
   parameter int  PBIT     = DEF_PBIT,
   parameter int  LOCKN    = DEF_LOCKN,
   parameter int  MSBFIRST = DEF_MSBFIRST,
   parameter int  VLDLOCK  = DEF_VLDLOCK,
   localparam int DATABIT  = DEMUX * LINEBIT
) (
   input  logic               rst_,
   input  logic               synclk,
   input  logic [LINEBIT-1:0] idat,
   input  logic               isyn,
   input  logic [BITTS-1:0]   capofs,
   output logic [DATABIT-1:0] odat,
   output logic               ovld,
   output logic               locked,
   output logic               synerr
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DLY  = 2'd1;
   localparam logic [1:0] ST_ASM  = 2'd2;

   localparam logic [BITTS-1:0] TS_LAST = BITTS'(MAXTS - 1);
   localparam logic [PHBIT-1:0] PH_LAST = PHBIT'(DEMUX - 1);

   logic [2:0]         syn_sr;
   logic               posdet;
   logic [1:0]         state;
   logic [BITTS-1:0]   ofscnt;
   logic [BITTS-1:0]   ofs_sat;
   logic [BITTS-1:0]   cntts;
   logic [PHBIT-1:0]   cntph;
   logic [PHBIT-1:0]   samp_k;
   logic [PHBIT-1:0]   slot;
   logic [DATABIT-1:0] asm_word;
   logic [DATABIT-1:0] word_nxt;
   logic               cap_now;
   logic               slot_now;
   logic               samp_now;
   logic               word_done;

   // Oldest-low, two-newest-high: a single high sample never qualifies.
   assign posdet  = (syn_sr == 3'b011);
   assign ofs_sat = (capofs > TS_LAST) ? TS_LAST : capofs;

   // A new sync edge always wins over a slot boundary of the word in flight.
   assign cap_now   = posdet ? (ofs_sat == '0)
                             : ((state == ST_DLY) && (ofscnt == BITTS'(1)));
   assign slot_now  = !posdet && (state == ST_ASM) && (cntts == TS_LAST);
   assign samp_now  = cap_now || slot_now;
   assign samp_k    = cap_now ? '0 : (cntph + 1'b1);
   assign word_done = samp_now && (samp_k == PH_LAST);
   assign slot      = (MSBFIRST != 0) ? (PH_LAST - samp_k) : samp_k;

   always_comb begin
      word_nxt = asm_word;
      word_nxt[int'(slot)*LINEBIT +: LINEBIT] = idat;
   end

   always_ff @(posedge synclk or negedge rst_) begin
      if (!rst_) begin
         syn_sr   <= '0;
         state    <= ST_IDLE;
         ofscnt   <= '0;
         cntts    <= '0;
         cntph    <= PH_LAST;
         asm_word <= '0;
         odat     <= '0;
         ovld     <= 1'b0;
      end else begin
         syn_sr <= {syn_sr[1:0], isyn};
         ovld   <= word_done && ((VLDLOCK == 0) || locked);
         if (samp_now) begin
            asm_word <= word_nxt;
         end
         if (word_done) begin
            odat <= word_nxt;
         end
         if (cap_now) begin
            cntts <= '0;
            cntph <= '0;
            state <= (DEMUX == 1) ? ST_IDLE : ST_ASM;
         end else if (posdet) begin
            ofscnt <= ofs_sat;
            cntph  <= PH_LAST;
            state  <= ST_DLY;
         end else begin
            case (state)
               ST_DLY: ofscnt <= ofscnt - 1'b1;
               ST_ASM: begin
                  if (cntts == TS_LAST) begin
                     cntts <= '0;
                     cntph <= cntph + 1'b1;
                     if (word_done) begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     cntts <= cntts + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   intfsynmon #(
      .SYNPER(SYNPER),
      .PBIT  (PBIT),
      .LOCKN (LOCKN)
   ) u_synmon (
      .synclk(synclk),
      .rst_  (rst_),
      .posdet(posdet),
      .locked(locked),
      .synerr(synerr)
   );

endmodule

// File: tb/tb_intfdemuxn.sv
// Scoreboard bench for intfdemuxn: three instances (MSB-first, LSB-first,
// DEMUX=1 with VLDLOCK) share one directed sync/data stimulus.
module tb_intfdemuxn;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic       synclk = 1'b0;
   logic       rst_;
   logic [1:0] idat;
   logic       isyn;
   logic [2:0] capofs;

   logic [7:0] odat_a, odat_b;
   logic [1:0] odat_c;
   logic       ovld_a, ovld_b, ovld_c;
   logic       locked_a, locked_b, locked_c;
   logic       synerr_a, synerr_b, synerr_c;

   logic [7:0] odat_v[3];
   logic       ovld_v[3];
   logic       locked_v[3];
   logic       synerr_v[3];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 0;
   logic [1:0] plan[int];
   exp_t word_q[3][$];
   int   syn_q[3][$];

   always #3 synclk = ~synclk;
   always @(posedge synclk) cyc <= cyc + 1;

   intfdemuxn #(.LINEBIT(2), .DEMUX(4), .BITTS(3), .MAXTS(6), .SYNPER(24), .PBIT(8),
                .LOCKN(2), .MSBFIRST(1), .VLDLOCK(0)) u_a (
      .rst_(rst_), .synclk(synclk), .idat(idat), .isyn(isyn), .capofs(capofs),
      .odat(odat_a), .ovld(ovld_a), .locked(locked_a), .synerr(synerr_a));

   intfdemuxn #(.LINEBIT(2), .DEMUX(4), .BITTS(3), .MAXTS(6), .SYNPER(24), .PBIT(8),
                .LOCKN(2), .MSBFIRST(0), .VLDLOCK(0)) u_b (
      .rst_(rst_), .synclk(synclk), .idat(idat), .isyn(isyn), .capofs(capofs),
      .odat(odat_b), .ovld(ovld_b), .locked(locked_b), .synerr(synerr_b));

   intfdemuxn #(.LINEBIT(2), .DEMUX(1), .BITTS(3), .MAXTS(6), .SYNPER(24), .PBIT(8),
                .LOCKN(2), .MSBFIRST(1), .VLDLOCK(1)) u_c (
      .rst_(rst_), .synclk(synclk), .idat(idat), .isyn(isyn), .capofs(capofs),
      .odat(odat_c), .ovld(ovld_c), .locked(locked_c), .synerr(synerr_c));

   assign odat_v[0] = odat_a;
   assign odat_v[1] = odat_b;
   assign odat_v[2] = {6'b0, odat_c};
   assign ovld_v[0] = ovld_a;
   assign ovld_v[1] = ovld_b;
   assign ovld_v[2] = ovld_c;
   assign locked_v[0] = locked_a;
   assign locked_v[1] = locked_b;
   assign locked_v[2] = locked_c;
   assign synerr_v[0] = synerr_a;
   assign synerr_v[1] = synerr_b;
   assign synerr_v[2] = synerr_c;

   function automatic logic [7:0] rev(input logic [7:0] w);
      return {w[1:0], w[3:2], w[5:4], w[7:6]};
   endfunction

   task automatic chk(input string name, input int inst, input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s inst %0d cycle %0d: got %0h required %0h", name, inst, cyc, act, req);
      end
   endtask

   // Sample data is scheduled by absolute cycle; other cycles carry junk.
   always @(negedge synclk) begin
      if (plan.exists(cyc)) idat = plan[cyc];
      else                  idat = 2'($urandom);
   end

   always @(negedge synclk) begin : mon
      exp_t e;
      int   s;
      if (rst_ === 1'b1 && !done) begin
         for (int i = 0; i < 3; i++) begin
            if (word_q[i].size() > 0 && word_q[i][0].c < cyc) begin
               e = word_q[i].pop_front();
               checks++;
               errors++;
               $display("FAIL ovld_missing inst %0d: none by cycle %0d, required at cycle %0d data %0h",
                        i, cyc, e.c, e.d);
            end
            if (syn_q[i].size() > 0 && syn_q[i][0] < cyc) begin
               s = syn_q[i].pop_front();
               checks++;
               errors++;
               $display("FAIL synerr_missing inst %0d: none by cycle %0d, required at cycle %0d",
                        i, cyc, s);
            end
            if (ovld_v[i]) begin
               checks++;
               if (word_q[i].size() == 0) begin
                  errors++;
                  $display("FAIL ovld_unexpected inst %0d: ovld at cycle %0d data %0h, required none",
                           i, cyc, odat_v[i]);
               end else begin
                  e = word_q[i].pop_front();
                  if (e.c != cyc || e.d !== odat_v[i]) begin
                     errors++;
                     $display("FAIL ovld_word inst %0d: got %0h at cycle %0d, required %0h at cycle %0d",
                              i, odat_v[i], cyc, e.d, e.c);
                  end
               end
            end
            if (synerr_v[i]) begin
               checks++;
               if (syn_q[i].size() == 0) begin
                  errors++;
                  $display("FAIL synerr_unexpected inst %0d: pulse at cycle %0d, required none", i, cyc);
               end else begin
                  s = syn_q[i].pop_front();
                  if (s != cyc) begin
                     errors++;
                     $display("FAIL synerr_cycle inst %0d: got cycle %0d required cycle %0d", i, cyc, s);
                  end
               end
            end
         end
      end
   end

   // One sync frame starting at the current negedge: isyn rises now, so the
   // posdet cycle is p = n0+2 and capture is p + min(ofs,5).
   task automatic frame(input int ofs, input logic [7:0] w, input int len, input bit glitch,
                        input bit exp_ab, input bit exp_c, input bit err_p1, input bit miss,
                        input logic lk, input int rst_at);
      int   n0, p, c;
      exp_t e;
      n0 = cyc;
      p  = n0 + 2;
      c  = p + ((ofs > 5) ? 5 : ofs);
      capofs = 3'(ofs);
      if (!glitch) begin
         for (int k = 0; k < 4; k++) plan[c + 6*k] = w[7-2*k -: 2];
      end
      if (exp_ab) begin
         e.c = c + 19;
         e.d = w;       word_q[0].push_back(e);
         e.d = rev(w);  word_q[1].push_back(e);
      end
      if (exp_c) begin
         e.c = c + 1;
         e.d = {6'b0, w[7:6]};
         word_q[2].push_back(e);
      end
      for (int i = 0; i < 3; i++) begin
         if (err_p1) syn_q[i].push_back(p + 1);
         if (miss)   syn_q[i].push_back(p + 25);
      end
      for (int j = 0; j < len; j++) begin
         isyn = glitch ? (j == 0) : (j < 4);
         if (j == rst_at) begin
            rst_ = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
               chk("rst_odat", i, odat_v[i], 8'h00);
               chk("rst_ovld", i, {7'b0, ovld_v[i]}, 8'h00);
               chk("rst_locked", i, {7'b0, locked_v[i]}, 8'h00);
               chk("rst_synerr", i, {7'b0, synerr_v[i]}, 8'h00);
            end
         end
         if (j == rst_at + 2) rst_ = 1'b1;
         if (j == 3) begin
            for (int i = 0; i < 3; i++) chk("locked", i, {7'b0, locked_v[i]}, {7'b0, lk});
         end
         @(negedge synclk);
      end
   endtask

   initial begin
      rst_   = 1'b0;
      isyn   = 1'b0;
      capofs = 3'd0;
      repeat (3) @(negedge synclk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("init_odat", i, odat_v[i], 8'h00);
         chk("init_ovld", i, {7'b0, ovld_v[i]}, 8'h00);
         chk("init_locked", i, {7'b0, locked_v[i]}, 8'h00);
         chk("init_synerr", i, {7'b0, synerr_v[i]}, 8'h00);
      end
      @(negedge synclk);
      rst_ = 1'b1;
      repeat (4) @(negedge synclk);
      //    ofs  word   len glt ab c  e1 ms lk  rst
      frame(2, 8'hD8, 24, 0, 1, 0, 0, 0, 0, -1);  // first edge after reset
      frame(2, 8'h4E, 24, 0, 1, 0, 0, 0, 0, -1);
      frame(1, 8'hB1, 24, 0, 1, 1, 0, 0, 1, -1);  // lock reached
      frame(7, 8'h93, 24, 0, 1, 1, 0, 0, 1, -1);  // offset saturates to 5
      frame(5, 8'h6C, 21, 0, 0, 1, 0, 0, 1, -1);  // next edge cuts this word
      frame(0, 8'h1B, 24, 0, 1, 1, 1, 0, 0, -1);  // early edge at pcnt=20
      frame(3, 8'hE4, 24, 0, 1, 0, 0, 0, 0, -1);
      frame(3, 8'h72, 24, 0, 1, 1, 0, 0, 1, -1);
      frame(2, 8'hC9, 40, 0, 1, 1, 0, 1, 1, -1);  // sync stops: missing
      frame(2, 8'h5A, 24, 0, 1, 0, 0, 0, 0, -1);  // late edge, no second synerr
      frame(2, 8'h00, 24, 1, 0, 0, 1, 0, 0, -1);  // glitch only; period lapses
      frame(2, 8'h8D, 24, 0, 1, 0, 0, 0, 0, -1);
      frame(2, 8'h36, 24, 0, 1, 0, 0, 0, 0, -1);
      frame(2, 8'hA7, 24, 0, 1, 1, 0, 0, 1, -1);
      frame(2, 8'hF0, 24, 0, 0, 1, 0, 0, 1, 12);  // reset mid-assembly
      frame(2, 8'h0F, 24, 0, 1, 0, 0, 0, 0, -1);  // first edge after reset
      frame(4, 8'h55, 24, 0, 1, 0, 0, 1, 0, -1);
      isyn = 1'b0;
      repeat (10) @(negedge synclk);
      for (int i = 0; i < 3; i++) begin
         chk("word_q_drained", i, 8'(word_q[i].size()), 8'h00);
         chk("syn_q_drained", i, 8'(syn_q[i].size()), 8'h00);
      end
      done = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
